serial_adder: RTL

Bit-serial add/subtract unit for the ALU datapath. It drives the team's 1-bit full-adder cell (FA) one bit per clock, LSB first, and keeps the carry in a flip-flop between bits. It trades WIDTH cycles of latency for a single adder cell. It is a multi-cycle alternative to a ripple adder and feeds its result and flags to the ALU result mux.

---
 rtl/serial_alu_pkg.sv | 33 +++
 rtl/serial_adder_fa.sv | 25 ++
 rtl/serial_adder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared types and constants for the bit-serial ALU datapath
//
// Purpose:
//   State encoding, default operand width and counter sizing shared by the
//   serial adder and any testbench or neighbouring ALU block that needs to
//   agree on them.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width
//   state_e        FSM state encoding (S_IDLE, S_RUN, S_DONE)
//   cnt_width()    bit-counter width for a given operand width

package serial_alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter must hold 0..WIDTH-1. Never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - single-bit full-adder cell
//
// Purpose:
//   Purely combinational 1-bit full adder; the serial adder drives one of
//   these per clock, LSB first.
//
// Ports:
//   a_i   in   operand A bit
//   b_i   in   operand B bit (already inverted by the caller for subtract)
//   ci_i  in   carry in
//   s_o   out  sum bit
//   co_o  out  carry out

module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit built around one full-adder cell
//
// Purpose:
//   Computes a+b+cin or a-b one bit per clock, LSB first, keeping the carry
//   in a flip-flop between bits. WIDTH cycles of latency per operation, one
//   result per WIDTH+1 cycles when started back-to-back.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation; honoured only in IDLE or DONE
//   sub    in   0: a+b+cin, 1: a-b (cin ignored)
//   a      in   operand A, sampled on the accepting edge
//   b      in   operand B, sampled on the accepting edge
//   cin    in   carry in for add mode
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when s/cout/ovf have just been updated
//   s      out  sum or difference, held until the next done
//   cout   out  carry out of the MSB (subtract: 1 means no borrow)
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)

module serial_adder
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic [WIDTH-1:0] r_next;

  serial_adder_fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Result register fills from the MSB end so that after WIDTH shifts the
  // first (LSB) sum bit lands in bit 0.
  assign r_next = {fa_s, r_sh_q[WIDTH-1:1]};

  // A new operation can only be taken when no bits are in flight.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d  = r_next;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;

        // Carry out of bit WIDTH-2 is the carry into the MSB; needed for ovf.
        if (cnt_q == CNT_MSB_IN) begin
          c_msb_d = fa_co;
        end

        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          s_d     = r_next;
          cout_d  = fa_co;
          ovf_d   = c_msb_q ^ fa_co;
        end
      end

      S_DONE: begin
        state_d = start ? S_RUN : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operand load is common to IDLE and DONE. Subtract is a + ~b + 1.
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode straight from registered state, so busy and done are
  // mutually exclusive by construction.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
